// File: rtl/bpm_uart_reporter_if.sv
// BPM reading handshake between DigitalBlock (master) and the reporter (slave).
//   bpm_value  : 8-bit unsigned BPM reading
//   bpm_valid  : reading available, held by the producer until acknowledged
//   bpm_copied : one-cycle acknowledge back to the producer
interface bpm_uart_reporter_if;
  logic [7:0] bpm_value;
  logic       bpm_valid;
  logic       bpm_copied;

  modport master (output bpm_value, output bpm_valid, input bpm_copied);
  modport slave  (input bpm_value, input bpm_valid, output bpm_copied);
endinterface

// File: rtl/bpm_uart_reporter.sv
// Captures BPM readings from DigitalBlock, rejects out-of-range values,
// keeps a 4-sample moving average and sends every new full-history average
// as one 8N1 UART byte (LSB first).
// Ports:
//   clk, rst_n     : system clock, synchronous active-low reset
//   en_i           : capture enable (0 blocks new captures only)
//   bpm_if         : reading handshake (slave side)
//   avg_bpm_o      : current 4-sample average
//   avg_valid_o    : history holds 4 accepted samples
//   avg_strobe_o   : one-cycle pulse on each full-history average update
//   reject_cnt_o   : saturating count of out-of-range readings
//   uart_tx_o      : serial output, idle high
//   tx_busy_o      : frame on the line
module bpm_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned BPM_MIN      = 30,
  parameter int unsigned BPM_MAX      = 220
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  bpm_uart_reporter_if.slave   bpm_if,
  output logic [7:0]           avg_bpm_o,
  output logic                 avg_valid_o,
  output logic                 avg_strobe_o,
  output logic [7:0]           reject_cnt_o,
  output logic                 uart_tx_o,
  output logic                 tx_busy_o
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  MIN_V    = 8'(BPM_MIN);
  localparam logic [7:0]  MAX_V    = 8'(BPM_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  // capture stage
  logic       armed_q;
  logic       copied_q;
  logic       cap_vld_q;
  logic [7:0] cap_q;
  logic       capture;

  // validate / history stage
  logic [7:0] hist_q [4];
  logic [1:0] wp_q;
  logic [9:0] sum_q;
  logic [2:0] fill_q;
  logic       acc_q;
  logic [7:0] rej_q;
  logic       in_range;

  // average stage
  logic [7:0] avg_q;
  logic       avg_valid_q;
  logic       strobe_q;

  // transmitter
  tx_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  pend_q;
  logic        pend_vld_q;
  logic        tx;
  logic        busy;

  assign capture  = en_i && armed_q && bpm_if.bpm_valid;
  assign in_range = (cap_q >= MIN_V) && (cap_q <= MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q   <= 1'b1;
      copied_q  <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      copied_q  <= capture;
      cap_vld_q <= capture;
      if (capture) begin
        cap_q   <= bpm_if.bpm_value;
        armed_q <= 1'b0;
      end else if (!bpm_if.bpm_valid) begin
        // re-arm only once the producer has dropped valid
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
      wp_q   <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      acc_q  <= 1'b0;
      rej_q  <= '0;
    end else begin
      acc_q <= 1'b0;
      if (cap_vld_q) begin
        if (!in_range) begin
          if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
        end else begin
          // unfilled slots are still 0, so subtracting them is harmless
          sum_q        <= sum_q - {2'b00, hist_q[wp_q]} + {2'b00, cap_q};
          hist_q[wp_q] <= cap_q;
          wp_q         <= wp_q + 2'd1;
          if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
          acc_q        <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (acc_q) begin
        avg_q       <= sum_q[9:2];
        avg_valid_q <= (fill_q == 3'd4);
        strobe_q    <= (fill_q == 3'd4);
      end
    end
  end

  // Pending byte: in IDLE the FSM always loads (a fresh strobe beats an
  // older pending byte), so pending is simply cleared there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      pend_vld_q <= 1'b0;
    end else if (strobe_q) begin
      pend_q     <= avg_q;
      pend_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx      = 1'b1;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe_q || pend_vld_q) begin
          state_d = S_START;
          cnt_d   = BIT_LAST;
          shift_d = strobe_q ? avg_q : pend_q;
        end
      end
      S_START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = BIT_LAST;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        tx   = shift_q[bit_q];
        busy = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bpm_if.bpm_copied = copied_q;
  assign avg_bpm_o         = avg_q;
  assign avg_valid_o       = avg_valid_q;
  assign avg_strobe_o      = strobe_q;
  assign reject_cnt_o      = rej_q;
  assign uart_tx_o         = tx;
  assign tx_busy_o         = busy;

endmodule

// File: tb/tb_bpm_uart_reporter.sv
module tb_bpm_uart_reporter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] avg_bpm;
  logic       avg_valid;
  logic       avg_strobe;
  logic [7:0] reject_cnt;
  logic       uart_tx;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;

  int rx_q[$];

  bpm_uart_reporter_if bif ();

  bpm_uart_reporter #(
    .CLKS_PER_BIT(4),
    .BPM_MIN(30),
    .BPM_MAX(220)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en),
    .bpm_if(bif),
    .avg_bpm_o(avg_bpm),
    .avg_valid_o(avg_valid),
    .avg_strobe_o(avg_strobe),
    .reject_cnt_o(reject_cnt),
    .uart_tx_o(uart_tx),
    .tx_busy_o(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Serial receiver: decodes 8N1 frames at 4 clocks per bit, dropping any
  // frame interrupted by reset.
  initial begin : uart_rx
    logic [7:0] b;
    logic       stop_b;
    bit         ok;
    b      = '0;
    stop_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        ok = 1'b1;
        for (int i = 0; i < 9 && ok; i++) begin
          for (int j = 0; j < 4 && ok; j++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ok = 1'b0;
          end
          if (ok) begin
            if (i < 8) b[i] = uart_tx;
            else       stop_b = uart_tx;
          end
        end
        if (ok) begin
          chk("stop_bit", int'(stop_b), 1);
          rx_q.push_back(int'(b));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    bif.bpm_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_q.delete();
  endtask

  // Presents one reading and returns sampling the cycle after edge C+2.
  task automatic do_reading(input logic [7:0] v);
    bit seen;
    seen          = 1'b0;
    bif.bpm_value = v;
    bif.bpm_valid = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bif.bpm_copied === 1'b1) seen = 1'b1;
    end
    chk("ack_seen", int'(seen), 1);
    bif.bpm_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_single", int'(bif.bpm_copied), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] v;
    int         rej;
    int         avg;
    int         vld;
    int         stb;
  } vec_t;

  vec_t tbl[12];

  // reference model state
  int acc_q[$];
  int m_rej;
  int m_avg;
  int m_vld;
  int exp_tx[$];

  initial begin
    logic [7:0] pat;
    int cnt;
    int exp_bit;
    int s;
    int v;
    int stb;

    tbl[0]  = '{8'd60,  0, 15,  0, 0};
    tbl[1]  = '{8'd70,  0, 32,  0, 0};
    tbl[2]  = '{8'd80,  0, 52,  0, 0};
    tbl[3]  = '{8'd90,  0, 75,  1, 1};
    tbl[4]  = '{8'd100, 0, 85,  1, 1};
    tbl[5]  = '{8'd101, 0, 92,  1, 1};
    tbl[6]  = '{8'd101, 0, 98,  1, 1};
    tbl[7]  = '{8'd101, 0, 100, 1, 1};
    tbl[8]  = '{8'd29,  1, 100, 1, 0};
    tbl[9]  = '{8'd221, 2, 100, 1, 0};
    tbl[10] = '{8'd30,  2, 83,  1, 1};
    tbl[11] = '{8'd220, 2, 113, 1, 1};

    en            = 1'b1;
    bif.bpm_value = 8'd72;
    bif.bpm_valid = 1'b1;
    rst_n         = 1'b0;

    // reset held with a pending reading
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_copied", int'(bif.bpm_copied), 0);
      chk("rst_tx", int'(uart_tx), 1);
      chk("rst_busy", int'(tx_busy), 0);
      chk("rst_avg", int'(avg_bpm), 0);
      chk("rst_avg_valid", int'(avg_valid), 0);
      chk("rst_strobe", int'(avg_strobe), 0);
      chk("rst_reject", int'(reject_cnt), 0);
    end
    rst_n = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(bif.bpm_copied);
    end
    chk("rst_release_acks", cnt, 1);

    // handshake: valid held for 5 cycles gives exactly one ack at C+1
    do_reset();
    bif.bpm_value = 8'd72;
    bif.bpm_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hs_copied", int'(bif.bpm_copied), (i == 0) ? 1 : 0);
    end
    bif.bpm_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("hs_drop", int'(bif.bpm_copied), 0);
    bif.bpm_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_reack", int'(bif.bpm_copied), 1);
    bif.bpm_valid = 1'b0;
    @(posedge clk);
    #1;

    // enable low blocks capture
    en            = 1'b0;
    bif.bpm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("en_off_copied", int'(bif.bpm_copied), 0);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("en_on_copied", int'(bif.bpm_copied), 1);
    bif.bpm_valid = 1'b0;
    @(posedge clk);
    #1;

    // table: average fill, truncation, range boundaries
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_reading(tbl[i].v);
      chk("tbl_reject", int'(reject_cnt), tbl[i].rej);
      chk("tbl_avg", int'(avg_bpm), tbl[i].avg);
      chk("tbl_avg_valid", int'(avg_valid), tbl[i].vld);
      chk("tbl_strobe", int'(avg_strobe), tbl[i].stb);
    end
    // reject saturation: 300 rejects in total
    for (int i = 0; i < 298; i++) begin
      do_reading(($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 29))
                                             : 8'($urandom_range(221, 255)));
    end
    chk("reject_sat", int'(reject_cnt), 255);
    do_reading(8'd5);
    chk("reject_sat_hold", int'(reject_cnt), 255);

    // full frame for 0xA5
    do_reset();
    for (int i = 0; i < 4; i++) do_reading(8'd165);
    chk("frame_strobe", int'(avg_strobe), 1);
    chk("frame_avg", int'(avg_bpm), 165);
    pat = 8'hA5;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k < 4)       exp_bit = 0;
      else if (k < 36) exp_bit = int'(pat[(k - 4) / 4]);
      else             exp_bit = 1;
      chk("frame_tx", int'(uart_tx), exp_bit);
      chk("frame_busy", int'(tx_busy), 1);
    end
    @(posedge clk);
    #1;
    chk("frame_end_tx", int'(uart_tx), 1);
    chk("frame_end_busy", int'(tx_busy), 0);

    // reset during DATA aborts the frame
    do_reset();
    for (int i = 0; i < 4; i++) do_reading(8'd165);
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_busy", int'(tx_busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", int'(uart_tx), 1);
    chk("abort_busy", int'(tx_busy), 0);
    rst_n = 1'b1;

    // pending overwrite: 75 sent, 85 replaced by 95
    do_reset();
    for (int i = 0; i < 4; i++) do_reading(8'd75);
    chk("pend_avg75", int'(avg_bpm), 75);
    do_reading(8'd115);
    chk("pend_avg85", int'(avg_bpm), 85);
    chk("pend_busy", int'(tx_busy), 1);
    do_reading(8'd115);
    chk("pend_avg95", int'(avg_bpm), 95);
    cnt = 0;
    while (rx_q.size() < 2 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    repeat (60) @(posedge clk);
    #1;
    chk("pend_frames", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("pend_first", rx_q[0], 75);
      chk("pend_second", rx_q[1], 95);
    end

    // randomized readings against the reference model
    do_reset();
    acc_q.delete();
    exp_tx.delete();
    m_rej = 0;
    m_avg = 0;
    m_vld = 0;
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(15, 235));
      do_reading(8'(v));
      stb = 0;
      if (v < 30 || v > 220) begin
        if (m_rej < 255) m_rej++;
      end else begin
        acc_q.push_back(v);
        s = 0;
        for (int i = (acc_q.size() > 4) ? acc_q.size() - 4 : 0; i < acc_q.size(); i++)
          s += acc_q[i];
        m_avg = s / 4;
        m_vld = (acc_q.size() >= 4) ? 1 : 0;
        stb   = m_vld;
        if (stb == 1) exp_tx.push_back(m_avg);
      end
      chk("rnd_reject", int'(reject_cnt), m_rej);
      chk("rnd_avg", int'(avg_bpm), m_avg);
      chk("rnd_avg_valid", int'(avg_valid), m_vld);
      chk("rnd_strobe", int'(avg_strobe), stb);
      repeat (45) @(posedge clk);
      #1;
    end
    repeat (50) @(posedge clk);
    #1;
    chk("rnd_frames", rx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < rx_q.size(); i++)
      chk("rnd_byte", rx_q[i], exp_tx[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
